imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 32, number of 32-bit words in the target instruction memory (word-indexed).
REQ-002 Parameter CNT_W, default 6, width of word counters; SHALL hold DEPTH.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-005 start  input  1  one-cycle request to begin a program load.
REQ-006 num_words  input  CNT_W  words to load, sampled when start is accepted.
REQ-007 abort  input  1  cancel an in-progress load.
REQ-008 byte_in  input  8  program byte stream, little-endian within each word.
REQ-009 byte_valid  input  1  byte_in holds a valid byte.
REQ-010 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-011 WriteReg  output  32  word index for the instruction-memory write port.
REQ-012 WriteData  output  32  assembled instruction word.
REQ-013 RegWrite  output  1  one-cycle write strobe to the instruction memory.
REQ-014 cpu_hold  output  1  core held off fetch while a load is in progress.
REQ-015 busy  output  1  load in progress.
REQ-016 done  output  1  last load completed successfully; sticky.
REQ-017 err  output  1  last start rejected because num_words was 0 or greater than DEPTH; sticky.

Function
REQ-018 FSM states are IDLE, RECV, WRITE and DONE.
REQ-019 A byte transfer occurs only on a cycle with byte_valid=1 and byte_ready=1.
REQ-020 byte_ready SHALL be 1 only in RECV.
REQ-021 In IDLE or DONE, start with 1<=num_words<=DEPTH:
  - go to RECV;
  - latch num_words;
  - clear word index and byte count;
  - clear done and err.
REQ-022 In IDLE or DONE, start with num_words=0 or >DEPTH: set err, clear done, remain in current state, no write.
REQ-023 start while in RECV or WRITE SHALL be ignored.
REQ-024 RECV byte transfer with byte count k (0..3): place byte_in at WriteData bits [8k+7:8k], increment k.
REQ-025 A transfer with k=3 SHALL move to WRITE on the next edge; k wraps to 0.
REQ-026 WRITE lasts exactly one cycle:
  - RegWrite=1;
  - WriteReg = current word index, zero-extended to 32 bits;
  - WriteData = assembled word.
REQ-027 Write latency: RegWrite asserts in the cycle immediately after the edge that captured the 4th byte.
REQ-028 After WRITE, increment the word index.
  - If the index equals the latched num_words, go to DONE and set done.
  - Otherwise, return to RECV.
REQ-029 RegWrite SHALL be 0 in every state other than WRITE.
REQ-030 WriteReg and WriteData are don't-care when RegWrite=0.
REQ-031 cpu_hold = busy = 1 in RECV and WRITE; both are 0 in IDLE and DONE.
REQ-032 abort in RECV or WRITE SHALL return to IDLE on the next edge.
  - A partial word is discarded.
  - A WRITE cycle coincident with abort is suppressed (RegWrite=0).
  - done stays 0.
REQ-033 abort in IDLE or DONE is ignored; abort has priority over start in the same cycle.
REQ-034 byte_valid outside RECV is ignored; no byte is consumed.

Reset
REQ-035 On reset, the following SHALL be set on the next edge, overriding all other inputs:
  - state=IDLE;
  - word index=0; byte count=0; latched num_words=0;
  - RegWrite=0, byte_ready=0, cpu_hold=0, busy=0, done=0, err=0;
  - WriteReg=0, WriteData=0.
REQ-036 Reset mid-load SHALL abandon the load with no further RegWrite pulse.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding, DEPTH default and the word-width constant 32.
REQ-038 No sub-module.
  - Byte assembly and FSM live in imem_loader.
  - Outputs connect directly to the instruction memory write port (WriteReg, WriteData, RegWrite).

Verification
REQ-039 Load 2 words:
  - stimulus: start, num_words=2, bytes B3 00 A2 00 33 01 12 40 with byte_valid continuously 1;
  - response: RegWrite pulse with WriteReg=0, WriteData=00A200B3, then pulse with WriteReg=1, WriteData=40120133;
  - response: done=1, cpu_hold=0.
REQ-040 Backpressure/gaps:
  - stimulus: num_words=1, byte_valid toggled 1,0,1,0,...;
  - response: exactly one RegWrite with WriteData correct;
  - response: byte_ready=0 during WRITE, so a byte presented then is held until RECV.
REQ-041 Bounds:
  - start with num_words=0 -> err=1, busy=0, no RegWrite;
  - start with num_words=33 -> err=1, no RegWrite;
  - start with num_words=32 and 128 bytes -> 32 writes, last WriteReg=31, done=1.
REQ-042 Abort after 6 bytes of a 2-word load:
  - one RegWrite (index 0), then IDLE, done=0;
  - a new start with 4 bytes writes index 0.
REQ-043 Reset asserted on the cycle RegWrite would pulse:
  - no RegWrite;
  - all outputs 0 next cycle.
REQ-044 start during RECV is ignored; start from DONE reloads and clears done until completion.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// word width, default depth and the byte-lane insert helper.
package imem_loader_pkg;

    localparam int WORD_W        = 32;
    localparam int DEPTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Little-endian placement: lane k occupies bits [8k+7:8k].
    function automatic logic [WORD_W-1:0] insert_byte(
        input logic [WORD_W-1:0] word,
        input logic [1:0]        lane,
        input logic [7:0]        value
    );
        logic [WORD_W-1:0] result;
        result = word;
        case (lane)
            2'd0:    result[7:0]   = value;
            2'd1:    result[15:8]  = value;
            2'd2:    result[23:16] = value;
            2'd3:    result[31:24] = value;
            default: result        = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams a little-endian byte program into an instruction memory write
// port, holding the core off fetch while the load is in progress.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [WORD_W-1:0] WriteReg,
    output logic [WORD_W-1:0] WriteData,
    output logic              RegWrite,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_nx_s;
    logic [CNT_W-1:0]  word_idx_r, num_r, word_idx_inc_s;
    logic [1:0]        byte_cnt_r;
    logic [WORD_W-1:0] data_r;
    logic              done_r, err_r;
    logic              num_ok_s, accept_s, reject_s, xfer_s, write_s;

    assign num_ok_s       = (num_words != {CNT_W{1'b0}}) && ({1'b0, num_words} <= DEPTH_C);
    assign word_idx_inc_s = word_idx_r + ONE_C;

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        reject_s   = 1'b0;
        xfer_s     = 1'b0;
        write_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                // abort outranks start, so a simultaneous request is dropped
                if (start && !abort) begin
                    if (num_ok_s) begin
                        accept_s   = 1'b1;
                        state_nx_s = ST_RECV;
                    end else begin
                        reject_s   = 1'b1;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_RECV: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (byte_valid) begin
                    xfer_s = 1'b1;
                    if (byte_cnt_r == 2'd3) begin
                        state_nx_s = ST_WRITE;
                    end else begin
                        state_nx_s = ST_RECV;
                    end
                end else begin
                    state_nx_s = ST_RECV;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    write_s = 1'b1;
                    if (word_idx_inc_s == num_r) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_RECV;
                    end
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, counters, word assembly and sticky status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            word_idx_r <= {CNT_W{1'b0}};
            num_r      <= {CNT_W{1'b0}};
            byte_cnt_r <= 2'd0;
            data_r     <= {WORD_W{1'b0}};
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (accept_s) begin
                num_r      <= num_words;
                word_idx_r <= {CNT_W{1'b0}};
                byte_cnt_r <= 2'd0;
                data_r     <= {WORD_W{1'b0}};
                done_r     <= 1'b0;
                err_r      <= 1'b0;
            end else if (reject_s) begin
                err_r  <= 1'b1;
                done_r <= 1'b0;
            end else if (xfer_s) begin
                data_r     <= insert_byte(data_r, byte_cnt_r, byte_in);
                byte_cnt_r <= byte_cnt_r + 2'd1;
            end else if (write_s) begin
                word_idx_r <= word_idx_inc_s;
                if (word_idx_inc_s == num_r) begin
                    done_r <= 1'b1;
                end
            end
        end
    end

    // The strobe is gated by reset and abort so a pending write never escapes.
    assign RegWrite   = write_s && !reset;
    assign byte_ready = (state_r == ST_RECV);
    assign busy       = (state_r == ST_RECV) || (state_r == ST_WRITE);
    assign cpu_hold   = busy;
    assign done       = done_r;
    assign err        = err_r;
    assign WriteReg   = {{(WORD_W-CNT_W){1'b0}}, word_idx_r};
    assign WriteData  = data_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for the basic load and bounds,
// then hand-written sequences for gaps, full depth, abort, reset and restart.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset, start, abort, byte_valid;
    logic [5:0]  num_words;
    logic [7:0]  byte_in;
    logic        byte_ready, RegWrite, cpu_hold, busy, done, err;
    logic [31:0] WriteReg, WriteData;

    int checks = 0;
    int errors = 0;
    logic [63:0] wq[$];

    imem_loader dut (
        .clock(clock), .reset(reset), .start(start), .num_words(num_words),
        .abort(abort), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .WriteReg(WriteReg), .WriteData(WriteData),
        .RegWrite(RegWrite), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (RegWrite === 1'b1) begin
            wq.push_back({WriteReg, WriteData});
            check("ready_low_in_write", {63'd0, byte_ready}, 64'd0);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [5:0] n);
        start = 1'b1;
        num_words = n;
        cyc();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        byte_valid = 1'b1;
        byte_in = b;
        for (int i = 0; i < 10 && !ok; i++) begin
            #1;
            ok = byte_ready;
            cyc();
        end
        byte_valid = 1'b0;
        check("byte_accepted", {63'd0, ok}, 64'd1);
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 400 && !idle; i++) begin
            #1;
            idle = !busy;
            if (!idle) cyc();
        end
        check("load_finished", {63'd0, idle}, 64'd1);
    endtask

    typedef struct {
        logic        rst, st;
        logic [5:0]  nw;
        logic        ab, bv;
        logic [7:0]  bi;
        logic        rw;
        logic [31:0] wr, wd;
        logic        rdy, bsy, dn, er;
    } vec_t;

    vec_t vecs[20];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        rst   st    nw     ab    bv    bi      rw    wr      wd            rdy   bsy   dn    er
        vecs[0]  = '{1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 6'd2,  1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 8'hB3, 1'b0, 32'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 8'h00, 1'b0, 32'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 8'hA2, 1'b0, 32'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 8'h00, 1'b0, 32'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 8'h33, 1'b1, 32'd0, 32'h00A200B3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 8'h33, 1'b0, 32'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 8'h01, 1'b0, 32'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 8'h12, 1'b0, 32'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 8'h40, 1'b0, 32'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 1'b1, 32'd1, 32'h40120133, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 6'd0,  1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 6'd33, 1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 6'd1,  1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 6'd0,  1'b1, 1'b1, 8'h55, 1'b0, 32'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        num_words = 6'd0; byte_in = 8'h00;
        cyc();
        cyc();

        // Cycle table: row inputs apply in that cycle, outputs checked in it.
        for (int i = 0; i < 20; i++) begin
            reset = vecs[i].rst; start = vecs[i].st; num_words = vecs[i].nw;
            abort = vecs[i].ab; byte_valid = vecs[i].bv; byte_in = vecs[i].bi;
            #1;
            check($sformatf("row%0d_regwrite", i), {63'd0, RegWrite}, {63'd0, vecs[i].rw});
            check($sformatf("row%0d_ready", i), {63'd0, byte_ready}, {63'd0, vecs[i].rdy});
            check($sformatf("row%0d_busy", i), {62'd0, cpu_hold, busy}, {62'd0, vecs[i].bsy, vecs[i].bsy});
            check($sformatf("row%0d_done_err", i), {62'd0, done, err}, {62'd0, vecs[i].dn, vecs[i].er});
            if (vecs[i].rw || vecs[i].rst)
                check($sformatf("row%0d_wport", i), {WriteReg, WriteData}, {vecs[i].wr, vecs[i].wd});
            cyc();
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;

        // One word with byte_valid toggling.
        wq.delete();
        do_start(6'd1);
        send_byte(8'hDE); cyc();
        send_byte(8'hAD); cyc();
        send_byte(8'hBE); cyc();
        send_byte(8'hEF); cyc();
        wait_idle();
        check("gap_write_count", 64'(wq.size()), 64'd1);
        if (wq.size() > 0) check("gap_word", wq[0], {32'd0, 32'hEFBEADDE});
        check("gap_done", {63'd0, done}, 64'd1);

        // Full depth: 32 words from 128 bytes.
        wq.delete();
        do_start(6'd32);
        for (int i = 0; i < 128; i++) send_byte(8'(i));
        wait_idle();
        check("full_write_count", 64'(wq.size()), 64'd32);
        for (int k = 0; k < 32 && k < wq.size(); k++)
            check($sformatf("full_word%0d", k), wq[k],
                  {32'(k), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        check("full_done", {62'd0, done, err}, 64'd2);

        // Abort after six bytes of a two-word load, then reload one word.
        wq.delete();
        do_start(6'd2);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        #1;
        check("abort_write_count", 64'(wq.size()), 64'd1);
        if (wq.size() > 0) check("abort_word0", wq[0], {32'd0, 32'h04030201});
        check("abort_idle", {62'd0, busy, done}, 64'd0);
        do_start(6'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_idle();
        check("reload_write_count", 64'(wq.size()), 64'd2);
        if (wq.size() > 1) check("reload_word", wq[1], {32'd0, 32'h44332211});
        check("reload_done", {63'd0, done}, 64'd1);

        // start during RECV is ignored; restart from DONE clears done.
        wq.delete();
        do_start(6'd2);
        send_byte(8'hAA); send_byte(8'hBB);
        do_start(6'd1);
        send_byte(8'hCC); send_byte(8'hDD);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_idle();
        check("recv_start_count", 64'(wq.size()), 64'd2);
        if (wq.size() > 1) begin
            check("recv_start_word0", wq[0], {32'd0, 32'hDDCCBBAA});
            check("recv_start_word1", wq[1], {32'd1, 32'h04030201});
        end
        do_start(6'd1);
        #1;
        check("restart_clears_done", {62'd0, busy, done}, 64'd2);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
        wait_idle();
        check("restart_done", {63'd0, done}, 64'd1);
        check("restart_count", 64'(wq.size()), 64'd3);

        // Reset lands on the write cycle.
        wq.delete();
        do_start(6'd1);
        send_byte(8'h5A); send_byte(8'h6B); send_byte(8'h7C); send_byte(8'h8D);
        reset = 1'b1;
        #1;
        check("reset_write_suppressed", {63'd0, RegWrite}, 64'd0);
        cyc();
        reset = 1'b0;
        #1;
        check("reset_flags", {58'd0, RegWrite, byte_ready, cpu_hold, busy, done, err}, 64'd0);
        check("reset_wport", {WriteReg, WriteData}, 64'd0);
        cyc();
        check("reset_no_write", 64'(wq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
